mem_arbiter_pn: RTL and testbench

- Arbitrates one single-ported unified memory between the pipelined CPU's instruction-fetch port and its MEM-stage data port.
- Serialises accesses through a fixed-latency memory.
- Returns read data and a one-cycle ready pulse per port.
- Drives per-port stall lines that feed the pipeline's existing STALL/enable logic.
- Data port has priority; fetch has a bounded starvation limit.

---
 rtl/mem_arbiter_pn_pkg.sv | 21 ++
 rtl/arb_lat_cnt.sv | 31 +++
 rtl/mem_arbiter_pn.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter_pn.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pn_pkg.sv
// Shared types and defaults for the fetch/data unified-memory arbiter.
package mem_arbiter_pn_pkg;

    // Arbiter FSM encoding; values are fixed so debug tooling can decode them.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int DEF_AW         = 10;
    localparam int DEF_LAT        = 1;
    localparam int DEF_STARVE_MAX = 3;

    // Data port wins unless fetch is also waiting and has hit its starvation limit.
    function automatic logic data_wins(input logic dm_req, input logic if_req, input logic starved);
        return dm_req & (~if_req | ~starved);
    endfunction

endpackage

// File: rtl/arb_lat_cnt.sv
// Loadable up-counter that flags when the memory read latency has elapsed.
module arb_lat_cnt
    import mem_arbiter_pn_pkg::*;
#(
    parameter int LAT = DEF_LAT,
    parameter int CW  = $clog2(LAT + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          inc,
    output logic          done
);

    logic [CW-1:0] count;

    // Load takes precedence over increment; CW leaves headroom for one step past LAT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CW'(LAT));

endmodule

// File: rtl/mem_arbiter_pn.sv
// Arbiter sharing one fixed-latency single-ported memory between the
// instruction-fetch port and the MEM-stage data port.
//
// Handshake: a requester raises req with address/data stable and holds them
// until it sees its one-cycle ready pulse; ready completes exactly one access.
// Stall lines are req & ~ready and feed the pipeline enables directly.
module mem_arbiter_pn
    import mem_arbiter_pn_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int LAT        = DEF_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          pcrst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic [31:0]   dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          stall_if,
    output logic          stall_dm,
    output logic          gnt_dm,
    output arb_state_t    fsm_state
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(LAT + 2);

    arb_state_t    state;
    logic [SW-1:0] starve;
    logic          acc_we;
    logic          starved;
    logic          win_dm;
    logic          cnt_done;
    logic          unused_addr_bits;

    assign starved   = (starve >= SW'(STARVE_MAX));
    assign win_dm    = data_wins(dm_req, if_req, starved);
    assign stall_if  = if_req & ~if_ready;
    assign stall_dm  = dm_req & ~dm_ready;
    assign fsm_state = state;

    // Byte-offset and above-window address bits do not reach the memory.
    assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0], dm_addr[31:AW+2], dm_addr[1:0]};

    // Latency counter: loaded to 1 while in ISSUE, counts through WAIT.
    arb_lat_cnt #(
        .LAT (LAT),
        .CW  (CW)
    ) u_lat_cnt (
        .clk      (clk),
        .rst_n    (pcrst),
        .load     (state == ISSUE),
        .load_val (CW'(1)),
        .inc      (state == WAIT),
        .done     (cnt_done)
    );

    // Arbitration FSM with registered memory strobes, read data and ready pulses.
    always_ff @(posedge clk or negedge pcrst) begin
        if (!pcrst) begin
            state     <= IDLE;
            starve    <= '0;
            acc_we    <= 1'b0;
            gnt_dm    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
        end else begin
            // Strobes and ready pulses last exactly one cycle.
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        mem_en    <= 1'b1;
                        mem_wdata <= dm_wdata;
                        if (win_dm) begin
                            gnt_dm   <= 1'b1;
                            acc_we   <= dm_we;
                            mem_we   <= dm_we;
                            mem_addr <= dm_addr[AW+1:2];
                            if (if_req) begin
                                starve <= starve + 1'b1;
                            end
                        end else begin
                            gnt_dm   <= 1'b0;
                            acc_we   <= 1'b0;
                            mem_addr <= if_addr[AW+1:2];
                            starve   <= '0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt_done) begin
                        if (!acc_we) begin
                            if (gnt_dm) begin
                                dm_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                        if (gnt_dm) begin
                            dm_ready <= 1'b1;
                        end else begin
                            if_ready <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_pn.sv
// Directed bench for mem_arbiter_pn: three instances (LAT = 1, 3, 4) each with
// its own memory model; only the instance under test is held out of reset.
module tb_mem_arbiter_pn;
    import mem_arbiter_pn_pkg::*;

    logic        clk;
    logic [2:0]  rst_v;
    logic        mem_init;
    int          sel;
    int          n_checks;
    int          n_errors;

    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;

    logic [31:0] if_rdata_v  [3];
    logic        if_ready_v  [3];
    logic [31:0] dm_rdata_v  [3];
    logic        dm_ready_v  [3];
    logic        mem_en_v    [3];
    logic        mem_we_v    [3];
    logic [9:0]  mem_addr_v  [3];
    logic [31:0] mem_wdata_v [3];
    logic [31:0] mem_rdata_v [3];
    logic        stall_if_v  [3];
    logic        stall_dm_v  [3];
    logic        gnt_dm_v    [3];
    arb_state_t  st_v        [3];

    logic        exp_gnt [5];

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [9:0] a);
        if (a == 10'd4) return 32'h2002_0005;
        return {16'hC0DE, 6'd0, a};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [31:0] mem  [1024];
        logic [31:0] pipe [L];

        mem_arbiter_pn #(
            .AW         (10),
            .LAT        (L),
            .STARVE_MAX (3)
        ) u_dut (
            .clk       (clk),
            .pcrst     (rst_v[g]),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_rdata  (if_rdata_v[g]),
            .if_ready  (if_ready_v[g]),
            .dm_req    (dm_req),
            .dm_we     (dm_we),
            .dm_addr   (dm_addr),
            .dm_wdata  (dm_wdata),
            .dm_rdata  (dm_rdata_v[g]),
            .dm_ready  (dm_ready_v[g]),
            .mem_en    (mem_en_v[g]),
            .mem_we    (mem_we_v[g]),
            .mem_addr  (mem_addr_v[g]),
            .mem_wdata (mem_wdata_v[g]),
            .mem_rdata (mem_rdata_v[g]),
            .stall_if  (stall_if_v[g]),
            .stall_dm  (stall_dm_v[g]),
            .gnt_dm    (gnt_dm_v[g]),
            .fsm_state (st_v[g])
        );

        // Memory model: read data appears L cycles after the mem_en cycle, garbage otherwise.
        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 1024; i++) mem[i] <= init_word(10'(i));
            end else if (mem_en_v[g] && mem_we_v[g]) begin
                mem[mem_addr_v[g]] <= mem_wdata_v[g];
            end
            pipe[0] <= mem_en_v[g] ? mem[mem_addr_v[g]] : 32'hBADD_A7A0;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata_v[g] = pipe[L-1];
    end

    // Checker
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic select_dut(input int s);
        rst_v = 3'b000;
        next_cycle();
        next_cycle();
        sel = s;
        rst_v[s] = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sel      = 0;
        rst_v    = 3'b000;
        mem_init = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;

        // Reset state, LAT=1 instance
        select_dut(0);
        sample();
        chk("rst_state", 32'(st_v[sel]), 32'(IDLE));
        chk("rst_mem_en", mem_en_v[sel], 0);
        chk("rst_mem_addr", mem_addr_v[sel], 0);
        chk("rst_if_ready", if_ready_v[sel], 0);
        chk("rst_dm_ready", dm_ready_v[sel], 0);
        chk("rst_gnt_dm", gnt_dm_v[sel], 0);
        chk("rst_if_rdata", if_rdata_v[sel], 0);

        // Single fetch, LAT=1
        next_cycle(); if_req = 1'b1; if_addr = 32'h0000_0010;
        sample();
        chk("f_stall_c0", stall_if_v[sel], 1);
        chk("f_en_c0", mem_en_v[sel], 0);
        next_cycle(); sample();
        chk("f_en_c1", mem_en_v[sel], 1);
        chk("f_addr_c1", mem_addr_v[sel], 4);
        chk("f_we_c1", mem_we_v[sel], 0);
        chk("f_gnt_c1", gnt_dm_v[sel], 0);
        chk("f_stall_c1", stall_if_v[sel], 1);
        next_cycle(); sample();
        chk("f_en_c2", mem_en_v[sel], 0);
        chk("f_rdy_c2", if_ready_v[sel], 0);
        chk("f_stall_c2", stall_if_v[sel], 1);
        next_cycle(); sample();
        chk("f_rdy_c3", if_ready_v[sel], 1);
        chk("f_rdata_c3", if_rdata_v[sel], 32'h2002_0005);
        chk("f_stall_c3", stall_if_v[sel], 0);
        next_cycle(); if_req = 1'b0;
        sample();
        chk("f_rdy_c4", if_ready_v[sel], 0);
        chk("f_state_c4", 32'(st_v[sel]), 32'(IDLE));

        // Data write then readback
        next_cycle(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF;
        sample();
        chk("w_stall_c0", stall_dm_v[sel], 1);
        next_cycle(); sample();
        chk("w_en_c1", mem_en_v[sel], 1);
        chk("w_we_c1", mem_we_v[sel], 1);
        chk("w_addr_c1", mem_addr_v[sel], 8);
        chk("w_wdata_c1", mem_wdata_v[sel], 32'hDEAD_BEEF);
        chk("w_gnt_c1", gnt_dm_v[sel], 1);
        next_cycle(); sample();
        chk("w_we_c2", mem_we_v[sel], 0);
        next_cycle(); sample();
        chk("w_rdy_c3", dm_ready_v[sel], 1);
        chk("w_rdata_c3", dm_rdata_v[sel], 0);
        chk("w_ifdata_c3", if_rdata_v[sel], 32'h2002_0005);
        next_cycle(); dm_req = 1'b0; dm_we = 1'b0;
        sample();
        next_cycle(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        sample();
        next_cycle(); sample();
        chk("rb_en_c1", mem_en_v[sel], 1);
        chk("rb_we_c1", mem_we_v[sel], 0);
        chk("rb_addr_c1", mem_addr_v[sel], 8);
        next_cycle(); sample();
        next_cycle(); sample();
        chk("rb_rdy_c3", dm_ready_v[sel], 1);
        chk("rb_rdata_c3", dm_rdata_v[sel], 32'hDEAD_BEEF);
        next_cycle(); dm_req = 1'b0;
        sample();

        // Simultaneous requests: data first, fetch right after
        next_cycle(); if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        sample();
        next_cycle(); sample();
        chk("s_en_c1", mem_en_v[sel], 1);
        chk("s_gnt_c1", gnt_dm_v[sel], 1);
        chk("s_addr_c1", mem_addr_v[sel], 8);
        next_cycle(); sample();
        next_cycle(); sample();
        chk("s_dmrdy_c3", dm_ready_v[sel], 1);
        chk("s_dmdata_c3", dm_rdata_v[sel], 32'hDEAD_BEEF);
        chk("s_ifrdy_c3", if_ready_v[sel], 0);
        chk("s_stallif_c3", stall_if_v[sel], 1);
        next_cycle(); dm_req = 1'b0;
        sample();
        chk("s_state_c4", 32'(st_v[sel]), 32'(IDLE));
        chk("s_gnthold_c4", gnt_dm_v[sel], 1);
        next_cycle(); sample();
        chk("s_en_c5", mem_en_v[sel], 1);
        chk("s_gnt_c5", gnt_dm_v[sel], 0);
        chk("s_addr_c5", mem_addr_v[sel], 4);
        next_cycle(); sample();
        next_cycle(); sample();
        chk("s_ifrdy_c7", if_ready_v[sel], 1);
        chk("s_ifdata_c7", if_rdata_v[sel], 32'h2002_0005);
        next_cycle(); if_req = 1'b0;
        sample();

        // Starvation limit: three data grants, then fetch, then data again
        exp_gnt = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        next_cycle(); if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        sample();
        for (int c = 1; c <= 19; c++) begin
            next_cycle(); sample();
            if ((c - 1) % 4 == 0) begin
                chk($sformatf("sv_en_c%0d", c), mem_en_v[sel], 1);
                chk($sformatf("sv_gnt_c%0d", c), gnt_dm_v[sel], exp_gnt[(c - 1) / 4]);
                chk($sformatf("sv_addr_c%0d", c), mem_addr_v[sel], exp_gnt[(c - 1) / 4] ? 32'd8 : 32'd4);
            end else begin
                chk($sformatf("sv_en_c%0d", c), mem_en_v[sel], 0);
            end
            if (c == 15) chk("sv_ifrdy_c15", if_ready_v[sel], 1);
            if (c == 19) chk("sv_dmrdy_c19", dm_ready_v[sel], 1);
        end
        next_cycle(); if_req = 1'b0; dm_req = 1'b0;
        sample();
        chk("sv_state_end", 32'(st_v[sel]), 32'(IDLE));

        // Reset in the 2nd WAIT cycle, LAT=3 instance
        select_dut(1);
        next_cycle(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        sample();
        next_cycle(); sample();
        chk("r_en_c1", mem_en_v[sel], 1);
        chk("r_gnt_c1", gnt_dm_v[sel], 1);
        next_cycle(); sample();
        chk("r_state_c2", 32'(st_v[sel]), 32'(WAIT));
        next_cycle(); rst_v[1] = 1'b0;
        #1;
        chk("r_state_rst", 32'(st_v[sel]), 32'(IDLE));
        chk("r_en_rst", mem_en_v[sel], 0);
        chk("r_addr_rst", mem_addr_v[sel], 0);
        chk("r_gnt_rst", gnt_dm_v[sel], 0);
        chk("r_rdy_rst", dm_ready_v[sel], 0);
        chk("r_rdata_rst", dm_rdata_v[sel], 0);
        next_cycle(); sample();
        chk("r_rdy_held", dm_ready_v[sel], 0);
        next_cycle(); rst_v[1] = 1'b1;
        sample();
        chk("r_state_rel", 32'(st_v[sel]), 32'(IDLE));
        for (int c = 1; c <= 5; c++) begin
            next_cycle(); sample();
            chk($sformatf("r_en_r%0d", c), mem_en_v[sel], (c == 1) ? 32'd1 : 32'd0);
            chk($sformatf("r_rdy_r%0d", c), dm_ready_v[sel], (c == 5) ? 32'd1 : 32'd0);
            if (c == 1) chk("r_gnt_r1", gnt_dm_v[sel], 1);
            if (c == 5) chk("r_rdata_r5", dm_rdata_v[sel], 32'hC0DE_0008);
        end
        next_cycle(); dm_req = 1'b0;
        sample();

        // LAT=4: ready 6 cycles after request, next mem_en 7 cycles after the first
        select_dut(2);
        next_cycle(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h14; if_req = 1'b1; if_addr = 32'h10;
        sample();
        for (int c = 1; c <= 13; c++) begin
            next_cycle();
            if (c == 7) dm_req = 1'b0;
            sample();
            chk($sformatf("l_en_c%0d", c), mem_en_v[sel], (c == 1 || c == 8) ? 32'd1 : 32'd0);
            chk($sformatf("l_dmrdy_c%0d", c), dm_ready_v[sel], (c == 6) ? 32'd1 : 32'd0);
            if (c == 6) chk("l_dmdata_c6", dm_rdata_v[sel], 32'hC0DE_0005);
            if (c == 8) chk("l_gnt_c8", gnt_dm_v[sel], 0);
            if (c == 13) begin
                chk("l_ifrdy_c13", if_ready_v[sel], 1);
                chk("l_ifdata_c13", if_rdata_v[sel], 32'h2002_0005);
            end
        end
        next_cycle(); if_req = 1'b0;
        sample();

        // Final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
